// File: rtl/mem_sram_ctrl_pkg.sv
// mem_sram_ctrl_pkg: shared state encoding and SRAM constants for the MEM-stage SRAM controller.
package mem_sram_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE} state_e;
  localparam logic [31:0] DEF_ADDR_BASE = 32'd1024;
  localparam int SRAM_DW = 16;
endpackage

// File: rtl/mem_sram_ctrl_wait_counter.sv
// mem_sram_ctrl_wait_counter: 4-bit per-half cycle counter with sync clear, enable and terminal count.
module mem_sram_ctrl_wait_counter #(
  parameter logic [3:0] LAST = 4'd4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [3:0] cnt_q;
  always_ff @(posedge clk) begin
    if (!rst || clr) cnt_q <= '0;
    else if (en) cnt_q <= cnt_q + 4'd1;
  end
  assign tc = en && cnt_q == LAST;
endmodule

// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: splits 32-bit loads/stores into two timed 16-bit SRAM accesses; ~ready freezes the pipeline.
module mem_sram_ctrl
  import mem_sram_ctrl_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = DEF_ADDR_BASE,
  parameter int          WAIT_CYCLES = 5,
  parameter int          SRAM_AW     = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [31:0]          address,
  input  logic [31:0]          write_data,
  output logic [31:0]          read_data,
  output logic                 ready,
  inout  wire  [SRAM_DW-1:0]   SRAM_DQ,
  output logic [SRAM_AW-1:0]   SRAM_ADDR,
  output logic                 SRAM_WE_N
);
  state_e state_q, state_d;
  logic [SRAM_AW-2:0] word_q, word_d, word_in;
  logic [31:0] data_q, data_d, rdata_q, rdata_d;
  logic tc, wr, rd, hi;
  assign word_in = (SRAM_AW-1)'((address - ADDR_BASE) >> 2);
  assign wr = state_q == WR_LO || state_q == WR_HI;
  assign rd = state_q == RD_LO || state_q == RD_HI;
  assign hi = state_q == WR_HI || state_q == RD_HI;
  mem_sram_ctrl_wait_counter #(.LAST(4'(WAIT_CYCLES - 1))) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(tc || !(wr || rd)),
    .en (wr || rd),
    .tc (tc)
  );
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (wr_en || rd_en) begin
        state_d = wr_en ? WR_LO : RD_LO;
        word_d  = word_in;
        data_d  = write_data;
      end
      WR_LO: state_d = tc ? WR_HI : WR_LO;
      WR_HI: state_d = tc ? DONE : WR_HI;
      RD_LO: if (tc) begin
        state_d        = RD_HI;
        rdata_d[15:0]  = SRAM_DQ;
      end
      RD_HI: if (tc) begin
        state_d        = DONE;
        rdata_d[31:16] = SRAM_DQ;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
    end
  end
  // last cycle of each write half releases WE_N while address and data stay put
  assign SRAM_WE_N = !(wr && !tc);
  assign SRAM_ADDR = {word_q, hi};
  assign SRAM_DQ   = wr ? (hi ? data_q[31:16] : data_q[15:0]) : 'z;
  assign read_data = rdata_q;
  assign ready     = (state_q == IDLE && !wr_en && !rd_en) || state_q == DONE;
endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb_mem_sram_ctrl: directed bench with a behavioural 16-bit SRAM and a load-result scoreboard.
module tb_mem_sram_ctrl;
  logic clk = 0, rst = 0, wr_en = 0, rd_en = 0, oe = 0, pend = 0;
  logic [31:0] address = 0, write_data = 0, read_data;
  logic ready, SRAM_WE_N;
  logic [17:0] SRAM_ADDR, paddr;
  logic [15:0] pdat;
  wire  [15:0] SRAM_DQ;
  logic [15:0] mem [256] = '{default: 16'h0};
  logic [31:0] shadow [int];
  logic [31:0] exp_q [$];
  int npass = 0, ntot = 0;
  always #5 clk = ~clk;
  mem_sram_ctrl #(.ADDR_BASE(32'd1024), .WAIT_CYCLES(5), .SRAM_AW(18)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N)
  );
  assign SRAM_DQ = (oe && SRAM_WE_N) ? mem[SRAM_ADDR[7:0]] : 'z;
  // write commits at the end of the hold cycle only if address and data were kept stable
  always @(posedge clk) begin
    if (!SRAM_WE_N) begin
      pend <= 1'b1;
      paddr <= SRAM_ADDR;
      pdat <= SRAM_DQ;
    end else begin
      pend <= 1'b0;
      if (pend && SRAM_ADDR == paddr && SRAM_DQ === pdat) mem[paddr[7:0]] <= pdat;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask
  task automatic access(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d, input int hold);
    int lat = -1;
    int key = int'((a - 32'd1024) >> 2);
    logic [31:0] hb = ((a - 32'd1024) >> 2) << 1;
    if (we) shadow[key] = d;
    else if (re) exp_q.push_back(shadow.exists(key) ? shadow[key] : 32'h0);
    oe = re && !we;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      @(negedge clk);
      wr_en = we && k < hold;
      rd_en = re && k < hold;
      address = k < hold ? a : $urandom;
      write_data = k < hold ? d : $urandom;
      #1;
      if (k == 3) chk("addr_lo", 32'(SRAM_ADDR), hb);
      if (k == 3) chk("we_n_mid", 32'(SRAM_WE_N), 32'(!we));
      if (k == 3 && oe) chk("dq_not_driven", 32'(SRAM_DQ), 32'(mem[SRAM_ADDR[7:0]]));
      if (k == 5) chk("we_n_hold", 32'(SRAM_WE_N), 32'd1);
      if (k == 8) chk("addr_hi", 32'(SRAM_ADDR), hb | 32'd1);
      if (ready) lat = k;
    end
    chk("latency", lat, 32'd11);
    if (re && !we) chk("read_data", read_data, exp_q.pop_front());
    oe = 0;
  endtask
  initial begin
    int hi_cnt = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_we_n", 32'(SRAM_WE_N), 32'd1);
    chk("rst_rdata", read_data, 32'h0);
    chk("rst_addr", 32'(SRAM_ADDR), 32'h0);
    @(negedge clk) rst = 1;
    access(1, 0, 32'd1028, 32'hDEADBEEF, 1);
    chk("t1_lo", 32'(mem[2]), 32'hBEEF);
    chk("t1_hi", 32'(mem[3]), 32'hDEAD);
    access(0, 1, 32'd1028, 32'h0, 1);
    access(1, 1, 32'd1024, 32'h12345678, 1);
    chk("t3_lo", 32'(mem[0]), 32'h5678);
    chk("t3_hi", 32'(mem[1]), 32'h1234);
    chk("t3_rdata_kept", read_data, 32'hDEADBEEF);
    access(1, 0, 32'd1032, 32'hCAFEF00D, 1);
    access(0, 1, 32'd1032, 32'h0, 1);
    repeat (3) begin
      @(negedge clk);
      #1;
      hi_cnt += int'(ready && SRAM_WE_N);
    end
    chk("t4_no_repeat", 32'(hi_cnt), 32'd3);
    access(0, 1, 32'd1024, 32'h0, 3);
    @(negedge clk);
    wr_en = 1;
    address = 32'd1032;
    write_data = 32'h77775555;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      wr_en = 0;
      rst = (k != 8);
    end
    @(negedge clk);
    #1;
    chk("t5_ready", 32'(ready), 32'd1);
    chk("t5_we_n", 32'(SRAM_WE_N), 32'd1);
    chk("t5_rdata", read_data, 32'h0);
    chk("t5_addr", 32'(SRAM_ADDR), 32'h0);
    oe = 1;
    #1;
    chk("t5_dq_hiz", 32'(SRAM_DQ), 32'(mem[0]));
    oe = 0;
    rst = 1;
    repeat (3) @(negedge clk);
    chk("t5_lo_written", 32'(mem[4]), 32'h5555);
    chk("t5_hi_untouched", 32'(mem[5]), 32'hCAFE);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end
endmodule
